// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port between NREQ requesters,
// with write-back bypass and a single registered response slot.
module regfile_read_arbiter #(
  parameter int NREQ = 3,
  parameter int BITS = 64,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [BITS-1:0]   rsp_data,
  output logic [4:0]        rf_raddr,
  input  logic [BITS-1:0]   rf_rdata,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [BITS-1:0]   wb_data
);

  // Handshakes: a request transfers on a cycle where req_valid[i] && req_ready[i];
  // a response transfers where rsp_valid && rsp_ready. The output slot may be
  // refilled in the same cycle it is drained, so a grant needs !rsp_valid || rsp_ready.

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  next_ptr;
  logic            found;
  logic            can_issue;
  logic            issue;
  logic [4:0]      gnt_addr;
  logic [BITS-1:0] cap_value;

  // Scan starting at rr_ptr, wrapping modulo NREQ; first pending requester wins.
  always_comb begin
    int idx;
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        gnt_id = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    can_issue = !rsp_valid || rsp_ready;
    issue     = rst_n && can_issue && found;
    req_ready = issue ? (NREQ'(1) << gnt_id) : '0;
    gnt_addr  = req_addr[5*int'(gnt_id) +: 5];
    rf_raddr  = issue ? gnt_addr : 5'd0;
    next_ptr  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
  end

  // x0 reads as zero and is never bypassed; otherwise a same-cycle write wins.
  always_comb begin
    cap_value = rf_rdata;
    if (gnt_addr == 5'd0) begin
      cap_value = '0;
    end else if (wb_en && (wb_addr == gnt_addr)) begin
      cap_value = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rr_ptr    <= '0;
    end else if (issue) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_id;
      rsp_data  <= cap_value;
      rr_ptr    <= next_ptr;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
